// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pad synchronisers, glitch filter, 11-bit frame FSM and output buffer.
// Define PS2_KBD_RX_FIFO_EN for a 4-entry FIFO output buffer; otherwise a single holding register.
module ps2_kbd_rx #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic       clk_chipset,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    input  logic       scancode_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam logic [63:0] TO_CYC = 64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1000000;
    localparam int unsigned TW = $clog2(TO_CYC + 64'd1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 64'd1);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FL_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
    logic [1:0]    s1_q, s2_q, filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];
    logic          clk_prev_q;
    logic          fall, dat;

    state_t        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          good, perr_d, ferr_d;
    logic          perr_q, ferr_q, ovf_q, oe_q;
    logic          rd, wr, full, ovf_d;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '{default: '0};
        for (int unsigned i = 0; i < 2; i++) begin
            if (s2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FL_LAST) filt_d[i] = s2_q[i];
                else fcnt_d[i] = fcnt_q[i] + FW'(1);
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];
    assign dat  = filt_q[1];

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        good    = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == IDLE) tmo_d = '0;
        else if (fall)       tmo_d = TW'(1);
        else                 tmo_d = tmo_q + TW'(1);
        case (state_q)
            IDLE: if (fall && !dat) begin
                state_d = DATA;
                bcnt_d  = '0;
            end
            DATA: if (fall) begin
                sr_d   = {dat, sr_q[7:1]};
                bcnt_d = bcnt_q + 3'd1;
                if (bcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                par_d   = dat;
                state_d = STOP;
            end
            STOP: if (fall) begin
                state_d = IDLE;
                perr_d  = ~(^{sr_q, par_q});
                ferr_d  = ~dat;
                good    = dat & (^{sr_q, par_q});
            end
            default: state_d = IDLE;
        endcase
        // A real edge on the expiry cycle restarts the gap instead of aborting.
        if (state_q != IDLE && !fall && tmo_q == TO_LAST) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    assign rd    = scancode_valid & scancode_ready;
    assign wr    = good & (~full | rd);
    assign ovf_d = good & full & ~rd;

`ifdef PS2_KBD_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wptr_q, rptr_q;
    logic [2:0] cnt_q;

    assign full           = (cnt_q == 3'd4);
    assign scancode       = mem_q[rptr_q];
    assign scancode_valid = (cnt_q != 3'd0);

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) mem_q[wptr_q] <= sr_q;
            wptr_q <= wptr_q + 2'(wr);
            rptr_q <= rptr_q + 2'(rd);
            cnt_q  <= cnt_q + 3'(wr) - 3'(rd);
        end
    end
`else
    logic [7:0] hold_q;
    logic       full_q;

    assign full           = full_q;
    assign scancode       = hold_q;
    assign scancode_valid = full_q;

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr) hold_q <= sr_q;
            full_q <= wr | (full_q & ~rd);
        end
    end
`endif

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= '1;
            s2_q       <= '1;
            filt_q     <= '1;
            fcnt_q     <= '{default: '0};
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            sr_q       <= '0;
            bcnt_q     <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            s1_q       <= {ps2_data_in, ps2_clk_in};
            s2_q       <= s1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            clk_prev_q <= filt_q[0];
            state_q    <= state_d;
            sr_q       <= sr_d;
            bcnt_q     <= bcnt_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
            oe_q       <= full & (state_q == IDLE);
        end
    end

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign ps2_clk_oe = oe_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: good/bad frames, timeout, glitch, overflow, mid-frame reset.
module tb_ps2_kbd_rx;

    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned FL     = 8;
    localparam int unsigned TO_US  = 200;
    localparam int unsigned TO_CYC = TO_US * CLK_HZ / 1000000;
    localparam int unsigned H      = 20;
`ifdef PS2_KBD_RX_FIFO_EN
    localparam int unsigned DEPTH  = 4;
`else
    localparam int unsigned DEPTH  = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pclk = 1'b1;
    logic       pdat = 1'b1;
    logic       ready = 1'b0;
    logic       oe, valid, perr, ferr, ovf;
    logic [7:0] code;

    int n_checks = 0, n_pass = 0;
    int n_vcyc = 0, n_xfer = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
    int s_vcyc, s_xfer, s_perr, s_ferr, s_ovf;
    logic [7:0] last_code = 8'h00;

    ps2_kbd_rx #(.CLK_HZ(CLK_HZ), .FILTER_LEN(FL), .TIMEOUT_US(TO_US)) dut (
        .clk_chipset   (clk),
        .reset_n       (reset_n),
        .ps2_clk_in    (pclk),
        .ps2_data_in   (pdat),
        .ps2_clk_oe    (oe),
        .scancode      (code),
        .scancode_valid(valid),
        .scancode_ready(ready),
        .parity_err    (perr),
        .frame_err     (ferr),
        .overflow      (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_vcyc++;
        if (valid && ready) begin
            n_xfer++;
            last_code = code;
        end
        if (perr) n_perr++;
        if (ferr) n_ferr++;
        if (ovf)  n_ovf++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic snap();
        s_vcyc = n_vcyc; s_xfer = n_xfer; s_perr = n_perr; s_ferr = n_ferr; s_ovf = n_ovf;
    endtask

    task automatic send_bit(input logic b);
        pdat = b;
        tick(H);
        pclk = 1'b0;
        tick(H);
        pclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ flip);
        send_bit(stop);
        pdat = 1'b1;
        tick(H);
    endtask

    initial begin
        int unsigned n;

        tick(5);
        chk("rst_code", code, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_oe", oe, 0);
        chk("rst_errs", {perr, ferr, ovf}, 0);
        reset_n = 1'b1;
        tick(10);

        ready = 1'b1;
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("good_vcyc", n_vcyc - s_vcyc, 1);
        chk("good_xfer", n_xfer - s_xfer, 1);
        chk("good_code", last_code, 8'h1C);
        chk("good_errs", (n_perr - s_perr) + (n_ferr - s_ferr) + (n_ovf - s_ovf), 0);

        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("par_perr", n_perr - s_perr, 1);
        chk("par_ferr", n_ferr - s_ferr, 0);
        chk("par_vcyc", n_vcyc - s_vcyc, 0);

        snap();
        send_frame(8'hF0, 1'b0, 1'b0);
        chk("stop_ferr", n_ferr - s_ferr, 1);
        chk("stop_perr", n_perr - s_perr, 0);
        chk("stop_vcyc", n_vcyc - s_vcyc, 0);

        // Start bit plus four data bits of 0x5A, then the clock stays high.
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        pdat = 1'b1;
        tick(H);
        pclk = 1'b0;
        n = 0;
        while (n < 600 && !ferr) begin
            tick(1);
            n++;
            if (n == H) pclk = 1'b1;
        end
        chk("tmo_latency", n, FL + TO_CYC + 2);
        tick(5);
        chk("tmo_ferr", n_ferr - s_ferr, 1);
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("tmo_next_code", last_code, 8'h5A);
        chk("tmo_next_xfer", n_xfer - s_xfer, 1);
        chk("tmo_next_ferr", n_ferr - s_ferr, 1);

        snap();
        pdat = 1'b0;
        tick(H);
        pclk = 1'b0;
        tick(3);
        pclk = 1'b1;
        tick(H);
        pdat = 1'b1;
        tick(H);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("glitch_code", last_code, 8'h1C);
        chk("glitch_xfer", n_xfer - s_xfer, 1);
        chk("glitch_errs", (n_perr - s_perr) + (n_ferr - s_ferr), 0);

        ready = 1'b0;
        snap();
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b0, 1'b1);
        chk("ovf_count", n_ovf - s_ovf, 5 - DEPTH);
        chk("ovf_oe", oe, 1);
        chk("ovf_errs", (n_perr - s_perr) + (n_ferr - s_ferr), 0);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            chk("drain_valid", valid, 1);
            chk("drain_code", code, i + 1);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
        end
        chk("drain_empty", valid, 0);
        tick(2);
        chk("drain_oe", oe, 0);

        ready = 1'b1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        tick(5);
        snap();
        reset_n = 1'b0;
        #1;
        chk("mrst_code", code, 8'h00);
        chk("mrst_valid", valid, 0);
        chk("mrst_oe", oe, 0);
        chk("mrst_errs", {perr, ferr, ovf}, 0);
        tick(3);
        reset_n = 1'b1;
        pdat = 1'b1;
        tick(TO_CYC + 100);
        chk("mrst_no_pulse", (n_perr - s_perr) + (n_ferr - s_ferr) + (n_ovf - s_ovf), 0);
        chk("mrst_no_valid", n_vcyc - s_vcyc, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("mrst_next_code", last_code, 8'h1C);
        chk("mrst_next_xfer", n_xfer - s_xfer, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, the clk_chipset frequency in Hz.
REQ-002 SHALL have parameter FILTER_LEN, default 8, the number of consecutive equal samples needed to change a filtered line level.
REQ-003 SHALL have parameter TIMEOUT_US, default 2000, the maximum gap between PS/2 clock falling edges inside a frame.
REQ-004 SHALL have port clk_chipset, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port ps2_clk_in, input, 1, the raw clkps2 pad level.
REQ-007 SHALL have port ps2_data_in, input, 1, the raw dataps2 pad level.
REQ-008 SHALL have port ps2_clk_oe, output, 1; when high the top level pulls clkps2 low (host inhibit).
REQ-009 SHALL have port scancode, output, 8, the received byte.
REQ-010 SHALL have port scancode_valid, output, 1, meaning scancode holds an unread byte.
REQ-011 SHALL have port scancode_ready, input, 1, the consumer accept.
REQ-012 SHALL have port parity_err, output, 1, a one-cycle pulse on a bad-parity frame.
REQ-013 SHALL have port frame_err, output, 1, a one-cycle pulse on a bad stop bit or a timeout.
REQ-014 SHALL have port overflow, output, 1, a one-cycle pulse when a good byte is dropped.

Function
REQ-015 SHALL pass each pad input through two synchronizer flops, then through a glitch filter that changes its output only after FILTER_LEN identical consecutive samples.
REQ-016 SHALL act only on falling edges of the filtered clock: one-cycle detect, filtered data sampled in the same cycle.
REQ-017 SHALL use FSM states IDLE, DATA, PARITY, STOP.
  - IDLE->DATA on an edge with data=0; an edge with data=1 stays in IDLE with no error.
  - DATA shifts 8 bits, LSB first, then goes to PARITY.
  - PARITY->STOP, latching the parity bit.
  - STOP->IDLE on the next edge.
REQ-018 SHALL check odd parity over the 8 data bits plus the parity bit; on failure, pulse parity_err in the cycle after the stop edge and discard the byte.
REQ-019 SHALL pulse frame_err and discard the byte when the stop bit is 0; a parity failure in the same frame also pulses parity_err.
REQ-020 SHALL, outside IDLE, count cycles since the last edge; at TIMEOUT_US*CLK_HZ/1e6 cycles it returns to IDLE and pulses frame_err for one cycle.
REQ-021 SHALL, on a good frame, write the byte to the output buffer in the cycle after the stop edge; with the buffer empty, scancode_valid rises in that same cycle.
REQ-022 SHALL hold scancode stable while scancode_valid=1 and scancode_ready=0; a transfer occurs on any cycle with both high.
REQ-023 SHALL drop a good byte arriving while the buffer is full, keep the buffer contents unchanged, and pulse overflow.
REQ-024 SHALL complete a write and a read in the same cycle on a full buffer without loss and without an overflow pulse.
REQ-025 SHALL assert ps2_clk_oe only while the buffer is full and the FSM is in IDLE; it deasserts in the cycle after the buffer stops being full.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously set: FSM=IDLE; shift register, bit counter, timeout counter and buffer pointers to 0; filter outputs to 1; scancode=8'h00; scancode_valid, parity_err, frame_err, overflow and ps2_clk_oe to 0.
REQ-027 SHALL discard a frame in progress when reset asserts mid-frame, with no error pulse after release.

Configuration
REQ-028 SHALL, with macro PS2_KBD_RX_FIFO_EN defined, use a 4-entry FIFO as the output buffer (full after 4 unread bytes, first-in first-out).
REQ-029 SHALL, without PS2_KBD_RX_FIFO_EN, use a single holding register as the output buffer (full with 1 unread byte); all other behaviour is identical.

Verification
REQ-030 SHALL cover: frame 0x1C with odd parity, scancode_ready=1 -> scancode_valid high for 1 cycle, scancode=8'h1C, no error pulses.
REQ-031 SHALL cover: frame 0x1C with the parity bit inverted -> one parity_err pulse, scancode_valid stays 0.
REQ-032 SHALL cover: stop bit 0 on 0xF0 -> one frame_err pulse; then a clock held high mid-frame after 4 data bits -> frame_err exactly at timeout, FSM back in IDLE, next frame 0x5A received correctly.
REQ-033 SHALL cover: scancode_ready=0, send 0x01..0x05 -> FIFO build holds 0x01..0x04 with one overflow pulse on 0x05; non-FIFO build holds 0x01 with overflow pulses on 0x02..0x05; ps2_clk_oe=1 while full.
REQ-034 SHALL cover: a 3-sample glitch on ps2_clk_in with FILTER_LEN=8 -> no edge detected, FSM state unchanged; reset_n pulsed mid-frame -> all outputs 0 and no error pulse after release.
